// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with a shared clock/reset pair.
// N lanes of DW bits each; lane 0 sits in the low bits of TDATA.
interface axi4_stream_if #(
   parameter int N  = 1,
   parameter int DW = 16
) (
   input logic ACLK,
   input logic ARESETn
);
   logic [N*DW-1:0] TDATA;
   logic [N-1:0]    TKEEP;
   logic            TLAST;
   logic            TVALID;
   logic            TREADY;

   modport snk (
      input  ACLK, ARESETn,
      input  TDATA, TKEEP, TLAST, TVALID,
      output TREADY
   );

   modport src (
      input  TREADY,
      output TDATA, TKEEP, TLAST, TVALID
   );
endinterface

// File: rtl/axi4_stream_pack.sv
// Packs single-lane stream beats into DNO-lane words.
// Lane 0 carries the oldest sample; TLAST closes a short word.
module axi4_stream_pack #(
   parameter int DNO = 2,
   parameter int DW  = 16
) (
   input logic         ena,
   input logic         clr,
   axi4_stream_if.snk  sti,
   axi4_stream_if.src  sto
);
   localparam int CW = $clog2(DNO);

   logic                     clk;
   logic                     rst_n;
   logic [CW-1:0]            cnt;
   logic [DNO-2:0][DW-1:0]   bdat;
   logic [DNO-2:0]           bkeep;
   logic [DNO-1:0][DW-1:0]   odat;
   logic [DNO-1:0][DW-1:0]   wdat;
   logic [DNO-1:0]           okeep;
   logic [DNO-1:0]           wkeep;
   logic                     olast;
   logic                     ovld;
   logic                     rdy;
   logic                     ifire;
   logic                     ofire;
   logic                     full;
   logic                     done;

   assign clk   = sti.ACLK;
   assign rst_n = sti.ARESETn;

   // rst_n term keeps TREADY low for the whole reset window
   assign rdy   = rst_n & ena & ~clr & (~ovld | sto.TREADY);
   assign ifire = sti.TVALID & rdy;
   assign ofire = ovld & ena & sto.TREADY;
   assign full  = (cnt == CW'(DNO - 1));
   assign done  = ifire & (full | sti.TLAST);

   for (genvar i = 0; i < DNO; i++) begin : g_lane
      if (i < DNO - 1) begin : g_buf
         assign wdat[i]  = (CW'(i) < cnt)  ? bdat[i]    :
                           (CW'(i) == cnt) ? sti.TDATA  : '0;
         assign wkeep[i] = (CW'(i) < cnt)  ? bkeep[i]   :
                           (CW'(i) == cnt) ? sti.TKEEP[0] : 1'b0;

         always_ff @(posedge clk) begin
            if (ifire & ~done & (cnt == CW'(i)))
               bdat[i] <= sti.TDATA;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               bkeep[i] <= 1'b0;
            else if (ifire & ~done & (cnt == CW'(i)))
               bkeep[i] <= sti.TKEEP[0];
         end
      end else begin : g_top
         assign wdat[i]  = (CW'(i) == cnt) ? sti.TDATA    : '0;
         assign wkeep[i] = (CW'(i) == cnt) ? sti.TKEEP[0] : 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         ovld  <= 1'b0;
         okeep <= '0;
         olast <= 1'b0;
      end else if (clr) begin
         cnt   <= '0;
         ovld  <= 1'b0;
      end else if (done) begin
         cnt   <= '0;
         ovld  <= 1'b1;
         okeep <= wkeep;
         olast <= sti.TLAST;
      end else begin
         if (ifire)
            cnt <= cnt + CW'(1);
         if (ofire)
            ovld <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (done)
         odat <= wdat;
   end

   assign sti.TREADY = rdy;
   assign sto.TVALID = ovld & ena;
   assign sto.TDATA  = odat;
   assign sto.TKEEP  = okeep;
   assign sto.TLAST  = olast;
endmodule

// File: tb/tb_axi4_stream_pack.sv
// Bench for axi4_stream_pack (DNO=2, DW=16): directed cases
// followed by random traffic against a sample-group scoreboard.
module tb_axi4_stream_pack;
   localparam int DNO = 2;
   localparam int DW  = 16;

   typedef struct {
      logic [DW-1:0] d;
      logic          k;
      logic          l;
   } samp_t;

   typedef struct {
      logic [DNO*DW-1:0] d;
      logic [DNO-1:0]    k;
      logic              l;
   } word_t;

   logic clk;
   logic rst_n;
   logic ena;
   logic clr;

   int checks;
   int errors;
   int nout;

   samp_t grp[$];
   word_t expq[$];

   axi4_stream_if #(.N(1),   .DW(DW)) sti (.ACLK(clk), .ARESETn(rst_n));
   axi4_stream_if #(.N(DNO), .DW(DW)) sto (.ACLK(clk), .ARESETn(rst_n));

   axi4_stream_pack #(.DNO(DNO), .DW(DW)) dut (
      .ena (ena),
      .clr (clr),
      .sti (sti),
      .sto (sto)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Build the word a group of accepted samples must produce
   function automatic word_t mkword();
      word_t w;
      w.d = '0;
      w.k = '0;
      w.l = 1'b0;
      for (int i = 0; i < grp.size(); i++) begin
         w.d[i*DW +: DW] = grp[i].d;
         w.k[i]          = grp[i].k;
         w.l             = grp[i].l;
      end
      return w;
   endfunction

   task automatic model_reset();
      grp.delete();
      expq.delete();
   endtask

   // Called just after a negedge with inputs set; returns at the next negedge
   task automatic step(output bit inf);
      bit    ev;
      bit    et;
      bit    outf;
      bit    c;
      samp_t s;
      word_t w;
      #1;
      ev = rst_n && ena && (expq.size() > 0);
      et = rst_n && ena && !clr && ((expq.size() == 0) || sto.TREADY);
      chk("tvalid", {63'd0, sto.TVALID}, {63'd0, ev});
      chk("tready", {63'd0, sti.TREADY}, {63'd0, et});
      inf  = sti.TVALID && et;
      outf = ev && sto.TREADY;
      s.d  = sti.TDATA;
      s.k  = sti.TKEEP[0];
      s.l  = sti.TLAST;
      c    = clr;
      if (outf) begin
         if (expq.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
         end else begin
            w = expq.pop_front();
            chk("out_data", {32'd0, sto.TDATA}, {32'd0, w.d});
            chk("out_keep", {62'd0, sto.TKEEP}, {62'd0, w.k});
            chk("out_last", {63'd0, sto.TLAST}, {63'd0, w.l});
         end
         nout++;
      end
      @(posedge clk);
      if (rst_n) begin
         if (c) begin
            model_reset();
         end else if (inf) begin
            grp.push_back(s);
            if (grp.size() == DNO || s.l) begin
               expq.push_back(mkword());
               grp.delete();
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [DW-1:0] d, input logic l,
                       output bit inf);
      sti.TVALID = 1'b1;
      sti.TDATA  = d;
      sti.TKEEP  = 1'b1;
      sti.TLAST  = l;
      step(inf);
      sti.TVALID = 1'b0;
   endtask

   task automatic idle(input int n);
      bit f;
      sti.TVALID = 1'b0;
      for (int i = 0; i < n; i++) step(f);
   endtask

   task automatic chkword(input string tag, input logic [31:0] d,
                          input logic [1:0] k, input logic l);
      chk({tag, "_v"}, {63'd0, sto.TVALID}, 64'd1);
      chk({tag, "_d"}, {32'd0, sto.TDATA}, {32'd0, d});
      chk({tag, "_k"}, {62'd0, sto.TKEEP}, {62'd0, k});
      chk({tag, "_l"}, {63'd0, sto.TLAST}, {63'd0, l});
   endtask

   initial begin
      bit f;
      int acc;
      int n0;
      checks     = 0;
      errors     = 0;
      nout       = 0;
      rst_n      = 1'b0;
      ena        = 1'b1;
      clr        = 1'b0;
      sti.TVALID = 1'b0;
      sti.TDATA  = '0;
      sti.TKEEP  = 1'b1;
      sti.TLAST  = 1'b0;
      sto.TREADY = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_tvalid", {63'd0, sto.TVALID}, 64'd0);
      chk("rst_tready", {63'd0, sti.TREADY}, 64'd0);
      chk("rst_tkeep", {62'd0, sto.TKEEP}, 64'd0);
      chk("rst_tlast", {63'd0, sto.TLAST}, 64'd0);
      rst_n = 1'b1;

      // two plain samples -> one full word
      send(16'h0001, 1'b0, f);
      send(16'h0002, 1'b0, f);
      chkword("w28", 32'h0002_0001, 2'b11, 1'b0);
      idle(1);

      // TLAST closes full and short words
      send(16'h00AA, 1'b0, f);
      send(16'h00BB, 1'b1, f);
      chkword("w29a", 32'h00BB_00AA, 2'b11, 1'b1);
      send(16'h00CC, 1'b1, f);
      chkword("w29b", 32'h0000_00CC, 2'b01, 1'b1);
      idle(1);

      // downstream stall, then release
      sto.TREADY = 1'b0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         send(16'h0100 + 16'(acc), 1'b0, f);
         if (f) acc++;
      end
      chk("stall_acc", 64'(acc), 64'd2);
      sto.TREADY = 1'b1;
      n0 = nout;
      for (int i = 0; i < 8; i++) begin
         send(16'h0100 + 16'(acc), 1'b0, f);
         if (f) acc++;
      end
      chk("b2b_outs", 64'(nout - n0), 64'd4);
      chk("b2b_acc", 64'(acc), 64'd10);
      idle(2);

      // enable gap inside a word
      send(16'h0011, 1'b0, f);
      ena = 1'b0;
      sti.TVALID = 1'b1;
      sti.TDATA  = 16'h0022;
      for (int i = 0; i < 3; i++) begin
         step(f);
         chk("ena_noacc", {63'd0, f}, 64'd0);
      end
      ena = 1'b1;
      send(16'h0022, 1'b0, f);
      chkword("w31", 32'h0022_0011, 2'b11, 1'b0);
      idle(1);

      // flush coincident with a completing beat
      send(16'h0033, 1'b0, f);
      clr = 1'b1;
      send(16'h0044, 1'b0, f);
      clr = 1'b0;
      chk("clr_noacc", {63'd0, f}, 64'd0);
      chk("clr_tvalid", {63'd0, sto.TVALID}, 64'd0);
      send(16'h0055, 1'b0, f);
      send(16'h0066, 1'b0, f);
      chkword("w32", 32'h0066_0055, 2'b11, 1'b0);
      idle(1);

      // async reset with a word held
      sto.TREADY = 1'b0;
      send(16'h0077, 1'b0, f);
      send(16'h0088, 1'b1, f);
      idle(1);
      chk("hold_tvalid", {63'd0, sto.TVALID}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tvalid", {63'd0, sto.TVALID}, 64'd0);
      chk("arst_tready", {63'd0, sti.TREADY}, 64'd0);
      model_reset();
      @(negedge clk);
      idle(1);
      rst_n = 1'b1;
      sto.TREADY = 1'b1;
      send(16'h0099, 1'b0, f);
      chk("rel_acc", {63'd0, f}, 64'd1);
      // reset again with only a partial word buffered
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      send(16'h00A1, 1'b0, f);
      send(16'h00A2, 1'b0, f);
      chkword("w33", 32'h00A2_00A1, 2'b11, 1'b0);
      idle(1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         sti.TVALID = ($urandom % 4) != 0;
         sti.TDATA  = 16'($urandom);
         sti.TKEEP  = ($urandom % 5) != 0;
         sti.TLAST  = ($urandom % 4) == 0;
         sto.TREADY = ($urandom % 3) != 0;
         ena        = ($urandom % 10) != 0;
         clr        = ($urandom % 25) == 0;
         step(f);
      end
      ena        = 1'b1;
      clr        = 1'b0;
      sto.TREADY = 1'b1;
      idle(4);
      chk("drain", 64'(expq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
